// File: rtl/demux_sequencer_if.sv
// Request handshake plus the registered demux drive lines of demux_sequencer.
interface demux_sequencer_if #(
   parameter int DEPTH = 4
) ();
   logic                     in_valid;
   logic                     in_ready;
   logic [1:0]               in_dest;
   logic                     in_data;
   logic                     s1;
   logic                     s2;
   logic                     a1;
   logic                     busy;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output in_valid, in_dest, in_data,
      input  in_ready, s1, s2, a1, busy, count
   );

   modport slave (
      input  in_valid, in_dest, in_data,
      output in_ready, s1, s2, a1, busy, count
   );
endinterface

// File: rtl/demux_sequencer.sv
// Buffers {dest,data} requests in a FIFO and presents each on s1/s2/a1
// for HOLD cycles, in arrival order, back-to-back when entries are waiting.
module demux_sequencer #(
   parameter int DEPTH = 4,
   parameter int HOLD  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   demux_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLD) + 1;

   typedef enum logic {IDLE, DRIVE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            s1_q, s1_d, s2_q, s2_d, a1_q, a1_d;
   logic            ready, push, pop;
   logic [2:0]      head;

   // Ready looks only at occupancy, so a full FIFO refuses even on a pop edge.
   assign ready = (count_q < CW'(DEPTH));
   assign push  = bus.in_valid & ready;
   assign head  = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         a1_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hold_q  <= hold_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         a1_q    <= a1_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.in_dest, bus.in_data};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_q != '0) state_d = DRIVE;
         DRIVE:   if (hold_q == '0 && count_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop    = 1'b0;
      hold_d = hold_q;
      s1_d   = s1_q;
      s2_d   = s2_q;
      a1_d   = a1_q;
      case (state_q)
         IDLE: begin
            a1_d = 1'b0;
            pop  = (count_q != '0);
         end
         DRIVE: begin
            if (hold_q != '0)       hold_d = hold_q - HW'(1);
            else if (count_q != '0) pop    = 1'b1;
            else                    a1_d   = 1'b0;
         end
         default: a1_d = 1'b0;
      endcase
      if (pop) begin
         s1_d   = head[2];
         s2_d   = head[1];
         a1_d   = head[0];
         hold_d = HW'(HOLD - 1);
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   assign bus.in_ready = ready;
   assign bus.s1       = s1_q;
   assign bus.s2       = s2_q;
   assign bus.a1       = a1_q;
   assign bus.busy     = (state_q == DRIVE);
   assign bus.count    = count_q;
endmodule

// File: tb/tb_demux_sequencer.sv
// Directed checks of demux_sequencer at HOLD=2, 8 and 3 sharing one stimulus.
module tb_demux_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic [1:0] dest = 2'd0;
   logic       data = 1'b0;

   always #5 clk = ~clk;

   demux_sequencer_if #(.DEPTH(4)) b2 ();
   demux_sequencer_if #(.DEPTH(4)) b8 ();
   demux_sequencer_if #(.DEPTH(4)) b3 ();

   assign b2.in_valid = valid;
   assign b2.in_dest  = dest;
   assign b2.in_data  = data;
   assign b8.in_valid = valid;
   assign b8.in_dest  = dest;
   assign b8.in_data  = data;
   assign b3.in_valid = valid;
   assign b3.in_dest  = dest;
   assign b3.in_data  = data;

   demux_sequencer #(.DEPTH(4), .HOLD(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   demux_sequencer #(.DEPTH(4), .HOLD(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   demux_sequencer #(.DEPTH(4), .HOLD(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

   // {s1, s2, a1, busy, count[2:0], in_ready}
   logic [7:0] o2, o8;
   assign o2 = {b2.s1, b2.s2, b2.a1, b2.busy, b2.count, b2.in_ready};
   assign o8 = {b8.s1, b8.s2, b8.a1, b8.busy, b8.count, b8.in_ready};

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      bit       rst;
      bit       v;
      bit [1:0] d;
      bit       x;
      bit [7:0] exp;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input bit r, input bit v, input bit [1:0] d, input bit x,
                               input bit [7:0] e);
      vec_t t;
      t.rst = r; t.v = v; t.d = d; t.x = x; t.exp = e;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      valid = 1'b0;
      dest  = 2'd0;
      data  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   logic [2:0] ent [6];
   int         k;
   logic       rb;

   initial begin
      // Single entry, HOLD=2
      tbl[0]  = mk(1, 1, 2'd2, 1, 8'b000_0_001_1);
      tbl[1]  = mk(0, 0, 2'd0, 0, 8'b101_1_000_1);
      tbl[2]  = mk(0, 0, 2'd0, 0, 8'b101_1_000_1);
      tbl[3]  = mk(0, 0, 2'd0, 0, 8'b100_0_000_1);
      tbl[4]  = mk(0, 0, 2'd0, 0, 8'b100_0_000_1);
      // Back-to-back dests 0..3; edge 3 is a push+pop at count 2
      tbl[5]  = mk(1, 1, 2'd0, 1, 8'b000_0_001_1);
      tbl[6]  = mk(0, 1, 2'd1, 1, 8'b001_1_001_1);
      tbl[7]  = mk(0, 1, 2'd2, 1, 8'b001_1_010_1);
      tbl[8]  = mk(0, 1, 2'd3, 1, 8'b011_1_010_1);
      tbl[9]  = mk(0, 0, 2'd0, 0, 8'b011_1_010_1);
      tbl[10] = mk(0, 0, 2'd0, 0, 8'b101_1_001_1);
      tbl[11] = mk(0, 0, 2'd0, 0, 8'b101_1_001_1);
      tbl[12] = mk(0, 0, 2'd0, 0, 8'b111_1_000_1);
      tbl[13] = mk(0, 0, 2'd0, 0, 8'b111_1_000_1);
      tbl[14] = mk(0, 0, 2'd0, 0, 8'b110_0_000_1);

      do_reset();
      chk("reset_state", o2, 8'b000_0_000_1);

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rst) do_reset();
         valid = tbl[i].v;
         dest  = tbl[i].d;
         data  = tbl[i].x;
         @(posedge clk); #1;
         chk($sformatf("vec%0d", i), o2, tbl[i].exp);
      end

      // Backpressure on HOLD=8: source holds each entry until accepted
      ent[0] = 3'b001; ent[1] = 3'b011; ent[2] = 3'b101;
      ent[3] = 3'b111; ent[4] = 3'b010; ent[5] = 3'b100;
      do_reset();
      k = 0;
      for (int c = 0; c < 50; c++) begin
         valid = (k < 6);
         {dest, data} = ent[(k < 6) ? k : 5];
         rb = b8.in_ready;
         @(posedge clk); #1;
         if (valid && rb) k++;
         if (c == 4)  chk("bp_full", {b8.in_ready, b8.count}, {1'b0, 3'd4});
         if (c == 8)  chk("bp_hold_e0", {b8.in_ready, o8[7:5]}, {1'b0, ent[0]});
         if (c == 9)  chk("bp_pop_ready", {b8.in_ready, b8.count, o8[7:5]}, {1'b1, 3'd3, ent[1]});
         if (c == 10) chk("bp_refill", {b8.in_ready, b8.count}, {1'b0, 3'd4});
         if (c >= 1 && (c - 1) % 8 == 0 && (c - 1) / 8 < 6)
            chk($sformatf("bp_order%0d", (c - 1) / 8), {b8.busy, o8[7:5]},
                {1'b1, ent[(c - 1) / 8]});
         if (c == 49) chk("bp_drain", {b8.busy, b8.a1, b8.count}, {1'b0, 1'b0, 3'd0});
      end
      valid = 1'b0;
      chk("bp_all_pushed", k, 6);

      // Asynchronous reset while busy with 3 entries buffered
      do_reset();
      ent[0] = 3'b111; ent[1] = 3'b001; ent[2] = 3'b011; ent[3] = 3'b101;
      for (int c = 0; c < 4; c++) begin
         valid = 1'b1;
         {dest, data} = ent[c];
         @(posedge clk); #1;
      end
      valid = 1'b0;
      chk("pre_reset", o8, 8'b111_1_011_1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", o8, 8'b000_0_000_1);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk($sformatf("rst_no_replay%0d", c), o8, 8'b000_0_000_1);
      end

      // Zero data, HOLD=3
      do_reset();
      valid = 1'b1; dest = 2'd3; data = 1'b0;
      @(posedge clk); #1;
      valid = 1'b0;
      chk("zd_accept", b3.count, 3'd1);
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (c <= 3) chk($sformatf("zd_drive%0d", c), {b3.s1, b3.s2, b3.a1, b3.busy}, 4'b1101);
         else        chk("zd_idle", {b3.s1, b3.s2, b3.a1, b3.busy, b3.count}, 7'b1100_000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
